// File: rtl/egd_stream_ctrl_if.sv
// Word-wide valid/ready handshake between a bitstream source and egd_stream_ctrl.
interface egd_stream_ctrl_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/egd_stream_ctrl.sv
// Double-buffered word-to-serial sequencer feeding an Exp-Golomb decoder,
// stopping after a programmed number of decoded symbols.
module egd_stream_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] sym_num,
  egd_stream_ctrl_if.slave src,
  output logic             dec_rst,
  output logic             si_data,
  input  logic             busy,
  input  logic             valid,
  output logic [CNT_W-1:0] sym_cnt,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             done,
  output logic             underrun
);

  localparam int REM_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FILL, S_STREAM, S_DONE, S_ERR
  } state_t;

  state_t            state_reg, state_next;
  logic              init_cnt_reg;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] hold_reg;
  logic [REM_W-1:0]  rem_reg;
  logic              hold_full_reg;
  logic              si_data_reg;
  logic [CNT_W-1:0]  sym_cnt_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [CNT_W-1:0]  sym_num_reg;

  logic              ready;
  logic              xfer;
  logic              in_stream;
  logic              advance;
  logic              rem_zero;
  logic              fill_load;
  logic              take_hold;
  logic              take_bypass;
  logic              next_bit;
  logic              starved;
  logic              sym_hit;
  logic              accept_start;
  logic [WORD_W-1:0] shift_adv;

  assign xfer         = src.in_valid && ready;
  assign in_stream    = (state_reg == S_STREAM);
  assign advance      = in_stream && !busy;
  assign rem_zero     = (rem_reg == '0);
  assign fill_load    = (state_reg == S_FILL) && hold_full_reg;
  // Priority of a non-stalled cycle: next bit, then hold word, then bypass.
  assign next_bit     = advance && !rem_zero;
  assign take_hold    = fill_load || (advance && rem_zero && hold_full_reg);
  assign take_bypass  = advance && rem_zero && !hold_full_reg && xfer;
  assign starved      = advance && rem_zero && !hold_full_reg && !xfer;
  assign sym_hit      = in_stream && valid && ((sym_cnt_reg + CNT_W'(1)) == sym_num_reg);
  assign accept_start = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign shift_adv    = shift_reg << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = (sym_num == '0) ? S_DONE : S_INIT;
        end
      end
      S_INIT: begin
        if (init_cnt_reg) begin
          state_next = S_FILL;
        end
      end
      S_FILL: begin
        if (hold_full_reg) begin
          state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        // Reaching the symbol target wins over a starved advance.
        if (sym_hit) begin
          state_next = S_DONE;
        end else if (starved) begin
          state_next = S_ERR;
        end
      end
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    dec_rst  = 1'b0;
    done     = 1'b0;
    underrun = 1'b0;
    case (state_reg)
      S_INIT: begin
        ready   = !hold_full_reg;
        dec_rst = 1'b1;
      end
      S_FILL, S_STREAM: ready    = !hold_full_reg;
      S_DONE:           done     = 1'b1;
      S_ERR:            underrun = 1'b1;
      default: ;
    endcase
  end

  assign src.in_ready = ready;
  assign si_data      = si_data_reg;
  assign sym_cnt      = sym_cnt_reg;
  assign bit_cnt      = bit_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt_reg  <= 1'b0;
      shift_reg     <= '0;
      hold_reg      <= '0;
      rem_reg       <= '0;
      hold_full_reg <= 1'b0;
      si_data_reg   <= 1'b0;
      sym_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      sym_num_reg   <= '0;
    end else begin
      init_cnt_reg <= (state_reg == S_INIT) ? ~init_cnt_reg : 1'b0;
      if (accept_start) begin
        // A new run flushes both buffers; si_data keeps its last value.
        shift_reg     <= '0;
        rem_reg       <= '0;
        hold_full_reg <= 1'b0;
        if (sym_num != '0) begin
          sym_num_reg <= sym_num;
          sym_cnt_reg <= '0;
          bit_cnt_reg <= '0;
        end
      end else begin
        if (take_hold) begin
          shift_reg   <= hold_reg;
          si_data_reg <= hold_reg[WORD_W-1];
          rem_reg     <= REM_LOAD;
        end else if (take_bypass) begin
          shift_reg   <= src.in_data;
          si_data_reg <= src.in_data[WORD_W-1];
          rem_reg     <= REM_LOAD;
        end else if (next_bit) begin
          shift_reg   <= shift_adv;
          si_data_reg <= shift_adv[WORD_W-1];
          rem_reg     <= rem_reg - REM_W'(1);
        end

        if (xfer && !take_bypass) begin
          hold_reg      <= src.in_data;
          hold_full_reg <= 1'b1;
        end else if (take_hold) begin
          hold_full_reg <= 1'b0;
        end

        if (fill_load) begin
          bit_cnt_reg <= CNT_W'(1);
        end else if (advance && !starved) begin
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
        end

        if (in_stream && valid) begin
          sym_cnt_reg <= sym_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_egd_stream_ctrl.sv
// Directed and randomized checks of egd_stream_ctrl against a word/bit-level
// reference model of the accepted stream, symbol count and run phase.
module tb_egd_stream_ctrl;
  localparam int WORD_W = 8;
  localparam int CNT_W  = 16;

  typedef enum int {PH_IDLE, PH_INIT, PH_FILL, PH_STREAM, PH_DONE, PH_ERR} phase_t;

  logic             clk = 1'b0;
  logic             rst, start, busy, valid;
  logic [CNT_W-1:0] sym_num;
  logic             dec_rst, si_data, done, underrun;
  logic [CNT_W-1:0] sym_cnt, bit_cnt;

  egd_stream_ctrl_if #(.WORD_W(WORD_W)) src ();

  egd_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .sym_num(sym_num), .src(src),
    .dec_rst(dec_rst), .si_data(si_data), .busy(busy), .valid(valid),
    .sym_cnt(sym_cnt), .bit_cnt(bit_cnt), .done(done), .underrun(underrun));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  phase_t            m_phase;
  int                m_init;
  logic [CNT_W-1:0]  m_bit, m_sym, m_target;
  logic              m_und;
  logic [WORD_W-1:0] acc[$];
  logic [WORD_W-1:0] feed[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit k of the current run: words in acceptance order, MSB first.
  function automatic logic exp_bit(input int k);
    logic [WORD_W-1:0] w;
    if (k < 0 || (k / WORD_W) >= acc.size()) return 1'bx;
    w = acc[k / WORD_W];
    return w[WORD_W-1-(k % WORD_W)];
  endfunction

  task automatic drive_in();
    if (feed.size() > 0) begin
      src.in_valid = 1'b1;
      src.in_data  = feed[0];
    end else begin
      src.in_valid = 1'b0;
      src.in_data  = '0;
    end
  endtask

  task automatic tick();
    logic              p_xfer  = src.in_valid && src.in_ready && !rst;
    logic [WORD_W-1:0] p_data  = src.in_data;
    logic              p_start = start;
    logic              p_busy  = busy;
    logic              p_valid = valid;
    logic              p_rst   = rst;
    logic [CNT_W-1:0]  p_num   = sym_num;
    logic              hit;
    @(posedge clk);
    #1;
    if (p_xfer) begin
      void'(feed.pop_front());
      $display("xfer word=%02h sym_cnt=%0d bit_cnt=%0d", p_data, sym_cnt, bit_cnt);
    end
    if (p_rst) begin
      m_phase = PH_IDLE; m_bit = '0; m_sym = '0; m_und = 1'b0;
      acc.delete();
    end else begin
      case (m_phase)
        PH_IDLE, PH_DONE: begin
          if (p_start) begin
            if (p_num == '0) begin
              m_phase = PH_DONE;
            end else begin
              acc.delete();
              m_target = p_num; m_sym = '0; m_bit = '0; m_init = 2;
              m_phase = PH_INIT;
            end
          end
        end
        PH_INIT: begin
          if (p_xfer) acc.push_back(p_data);
          m_init--;
          if (m_init == 0) m_phase = PH_FILL;
        end
        PH_FILL: begin
          if (acc.size() > 0) begin
            m_phase = PH_STREAM;
            m_bit = 16'd1;
          end
          if (p_xfer) acc.push_back(p_data);
        end
        PH_STREAM: begin
          hit = p_valid && ((m_sym + 16'd1) == m_target);
          if (p_valid) m_sym = m_sym + 16'd1;
          if (p_xfer) acc.push_back(p_data);
          if (!p_busy) begin
            if (int'(m_bit) < WORD_W * acc.size()) m_bit = m_bit + 16'd1;
            else if (!hit) begin
              m_phase = PH_ERR;
              m_und = 1'b1;
            end
          end
          if (hit) m_phase = PH_DONE;
        end
        default: ;
      endcase
    end
    chk("bit_cnt", bit_cnt, m_bit);
    chk("sym_cnt", sym_cnt, m_sym);
    chk("done", done, m_phase == PH_DONE);
    chk("underrun", underrun, m_und);
    chk("dec_rst", dec_rst, m_phase == PH_INIT);
    if (m_phase == PH_IDLE || m_phase == PH_DONE || m_phase == PH_ERR)
      chk("in_ready_off", src.in_ready, 0);
    if (m_phase == PH_IDLE)
      chk("si_idle", si_data, 0);
    else if (m_bit != '0 && (m_phase == PH_STREAM || m_phase == PH_DONE || m_phase == PH_ERR))
      chk("si_data", si_data, exp_bit(int'(m_bit) - 1));
    drive_in();
  endtask

  task automatic do_reset();
    feed.delete();
    drive_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_run(input logic [CNT_W-1:0] n);
    sym_num = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_stream();
    for (int n = 0; n < 40 && m_phase != PH_STREAM; n++) tick();
    chk("reach_stream", bit_cnt, 1);
  endtask

  initial begin
    logic [15:0] pat;
    logic        s0;
    logic [CNT_W-1:0] b0;
    rst = 1'b1; start = 1'b0; busy = 1'b0; valid = 1'b0; sym_num = '0;
    src.in_valid = 1'b0; src.in_data = '0;
    m_phase = PH_IDLE; m_init = 0; m_bit = '0; m_sym = '0; m_target = '0; m_und = 1'b0;

    do_reset();
    chk("rst_flags", {si_data, src.in_ready, dec_rst, done, underrun}, 0);

    // Basic two-word stream, then a reset in the middle of streaming.
    feed = '{8'hA5, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44};
    drive_in();
    start_run(16'd100);
    chk("init_dec_rst1", dec_rst, 1);
    tick();
    chk("init_dec_rst2", dec_rst, 1);
    tick();
    chk("fill_dec_rst", dec_rst, 0);
    tick();
    pat = 16'hA53C;
    for (int i = 0; i < 16; i++) begin
      chk("basic_bit", si_data, pat[15-i]);
      if (i == 15) chk("bit_cnt16", bit_cnt, 16);
      tick();
    end
    do_reset();
    chk("midrst_flags", {si_data, src.in_ready, dec_rst, done, underrun}, 0);
    chk("midrst_cnts", {sym_cnt, bit_cnt}, 0);

    // Busy stall on the sixth presented bit.
    feed = '{8'hA5, 8'h3C, 8'h5A};
    drive_in();
    start_run(16'd100);
    wait_stream();
    repeat (5) tick();
    chk("stall_pre_si", si_data, 1);
    busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_si", si_data, 1);
      chk("stall_bits", bit_cnt, 6);
    end
    busy = 1'b0;
    tick();
    chk("stall_next_si", si_data, 0);
    chk("stall_next_bits", bit_cnt, 7);
    do_reset();

    // Completion after three symbols, then a restart from DONE.
    feed = '{8'h96, 8'h0F, 8'hE1, 8'h72};
    drive_in();
    start_run(16'd3);
    wait_stream();
    valid = 1'b1; tick();
    valid = 1'b0; tick();
    valid = 1'b1; tick();
    tick();
    valid = 1'b0;
    chk("cmp_sym_cnt", sym_cnt, 3);
    chk("cmp_done", done, 1);
    chk("cmp_in_ready", src.in_ready, 0);
    s0 = si_data;
    b0 = bit_cnt;
    repeat (3) tick();
    chk("cmp_si_frozen", si_data, s0);
    chk("cmp_bits_frozen", bit_cnt, b0);
    start_run(16'd5);
    chk("restart_sym", sym_cnt, 0);
    chk("restart_bits", bit_cnt, 0);
    chk("restart_dec_rst", dec_rst, 1);
    do_reset();

    // Underrun after a single word; start is ignored in ERR.
    feed = '{8'hFF};
    drive_in();
    start_run(16'd100);
    wait_stream();
    repeat (7) tick();
    chk("und_bits8", bit_cnt, 8);
    chk("und_pre", underrun, 0);
    tick();
    chk("und_set", underrun, 1);
    chk("und_in_ready", src.in_ready, 0);
    chk("und_si_held", si_data, 1);
    start_run(16'd5);
    chk("und_start_ign", {underrun, dec_rst, done}, 3'b100);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("und_cleared", underrun, 0);

    // Zero target, then a bypass word on the rem==0 advance.
    chk("zero_pre_dec_rst", dec_rst, 0);
    start_run(16'd0);
    chk("zero_done", done, 1);
    chk("zero_dec_rst", dec_rst, 0);
    do_reset();
    feed = '{8'h81};
    drive_in();
    start_run(16'd100);
    wait_stream();
    repeat (7) tick();
    chk("byp_bits8", bit_cnt, 8);
    feed.push_back(8'h7E);
    drive_in();
    tick();
    chk("byp_msb", si_data, 0);
    chk("byp_no_und", underrun, 0);
    chk("byp_bits9", bit_cnt, 9);
    tick();
    chk("byp_bit2", si_data, 1);
    do_reset();

    // Randomized runs with stalls, symbol pulses, gaps and restarts.
    for (int c = 0; c < 2500; c++) begin
      if (m_phase == PH_ERR) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      busy  = ($urandom % 3) == 0;
      valid = ($urandom % 4) == 0;
      if (feed.size() < 2 && ($urandom % 4) != 0) feed.push_back(WORD_W'($urandom));
      drive_in();
      if (m_phase == PH_IDLE || m_phase == PH_DONE) begin
        start   = 1'b1;
        sym_num = (($urandom % 10) == 0) ? 16'd0 : CNT_W'($urandom_range(1, 14));
      end else begin
        start = ($urandom % 60) == 0;
      end
      tick();
      start = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/egd_stream_ctrl.md
Name: egd_stream_ctrl

Overview:
Sequencer between a word-wide bitstream source and the serial Exp-Golomb decoder (EGD).
- Accepts WORD_W-bit words over a valid/ready handshake and double-buffers them.
- Serializes each word MSB-first onto the decoder's si_data and honours the decoder's busy stall.
- Counts decoded symbols (decoder valid pulses) and stops the stream after a programmed number of symbols.

Parameters:
WORD_W, 8, input word width; bits are serialized MSB-first.
CNT_W, 16, width of the symbol target and of both counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins a decode run
sym_num  in  CNT_W  symbols to decode; latched on an accepted start
in_data  in  WORD_W  bitstream word
in_valid  in  1  in_data valid
in_ready  out  1  controller can accept a word
dec_rst  out  1  reset driven to the decoder
si_data  out  1  serial bit to the decoder
busy  in  1  decoder stall; hold si_data while high
valid  in  1  decoder symbol-valid pulse
sym_cnt  out  CNT_W  symbols decoded in the current run
bit_cnt  out  CNT_W  bits advanced in the current run
done  out  1  run complete (level)
underrun  out  1  sticky; stream starved

Behaviour:
- All registers update on the posedge of clk.
- rst (synchronous, active-high) forces the following, regardless of state; there are no partial-reset cases, and rst mid-run aborts it:
  - state IDLE
  - si_data=0, in_ready=0, dec_rst=0, done=0, underrun=0, sym_cnt=0, bit_cnt=0
  - shift register, remaining-bit count (rem) and hold_full all cleared
- Word transfer occurs on any cycle with in_valid && in_ready.
- in_ready = !hold_full, and only in states INIT, FILL and STREAM.
- States:
  - IDLE:
    - start with sym_num==0 -> DONE next cycle, without pulsing dec_rst.
    - start with sym_num!=0 -> latch sym_num, clear counters, go INIT.
  - INIT:
    - dec_rst=1 for exactly 2 cycles, then FILL.
    - Words may be accepted into the hold register during INIT.
  - FILL:
    - Wait for hold_full. Then move hold into the shift register, drive its MSB on si_data, set rem=WORD_W-1, bit_cnt=1, and go STREAM.
    - The first bit is on si_data the cycle STREAM is entered.
  - STREAM, once per cycle:
    - busy==1: si_data, shift, rem and bit_cnt are held.
    - busy==0 is an advance, resolved in priority order:
      a) rem>0: present next bit, rem--.
      b) rem==0 and hold_full: load hold into shift, present its MSB, rem=WORD_W-1. hold_full clears unless a transfer occurs in the same cycle.
      c) rem==0, hold empty, and a transfer this cycle: bypass in_data straight into shift, present its MSB, rem=WORD_W-1.
      d) Otherwise: underrun=1, si_data held, go ERR.
    - In cases a-c, bit_cnt++.
  - DONE:
    - done=1, in_ready=0, si_data frozen.
    - start re-runs IDLE start handling, with buffers flushed.
  - ERR:
    - in_ready=0, si_data frozen, underrun stays 1.
    - Exits only via rst; start is ignored.
- Symbol counting:
  - valid counts in STREAM only (sym_cnt++).
  - On the cycle sym_cnt becomes sym_num -> DONE next cycle.
  - valid in IDLE, INIT, FILL, DONE or ERR is ignored.
- Simultaneous events in STREAM:
  - Completion beats underrun in the same cycle.
  - start is ignored outside IDLE and DONE.
- Counters wrap modulo 2^CNT_W, with no saturation.
- Latency: si_data changes one cycle after a non-busy cycle. There is no bubble between words while the hold register or the input is ready in time.

Test Plan:
- Reset: assert rst for 2 cycles mid-STREAM -> next cycle si_data=0, in_ready=0, dec_rst=0, done=0, underrun=0, sym_cnt=0, bit_cnt=0.
- Basic stream: start with sym_num=100, words 0xA5 then 0x3C always valid, busy=0 -> dec_rst high 2 cycles; si_data from the first STREAM cycle = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 with no gap at the word boundary; bit_cnt=16 after the 16th bit.
- Busy stall: busy=1 for 3 cycles while bit 5 of 0xA5 (value 1) is presented -> si_data=1 and bit_cnt unchanged for 3 cycles; bit 6 (0) appears one cycle after busy falls.
- Completion: sym_num=3, three valid pulses -> sym_cnt=3; done=1 the next cycle; in_ready=0; si_data frozen. A start then clears sym_cnt and bit_cnt and pulses dec_rst again.
- Underrun: supply a single word 0xFF, then in_valid=0, busy=0 -> the advance after the 8th bit sets underrun=1 and enters ERR; a later start has no effect; rst clears underrun.
- Zero target and bypass: start with sym_num=0 -> done=1 one cycle later, with dec_rst never high. Separately, deliver a word exactly on the rem==0 advance cycle with hold empty -> its MSB appears next cycle and underrun stays 0.
